vram_write_scheduler: RTL
=========================

// Module: vram_write_scheduler
// PURPOSE
//  Owns the single write port of the text-mode video RAM inside vga_display.
//  Clears the 80x25 screen on reset and on demand, holding the display in reset meanwhile.
//  Between clears it shares the port between the CPU and the keyboard/console writer.
//  Sharing is round-robin with a req/ack handshake; outputs drive vga_display addr/data/we directly.
// PARAMETERS
//  COLS        80      text columns
//  ROWS        25      text rows; SCREEN_CELLS = COLS*ROWS = 2000
//  ADDR_W      12      VRAM address width
//  DATA_W      16      cell width: {attr[15:8], char[7:0]}
//  CLEAR_CELL  16'h0700 value written to every cell by a clear (grey-on-black, NUL)
// PORTS
//  clk           in  1       system clock (global_clk, 50 MHz)
//  rst_n         in  1       asynchronous reset, active-low
//  clear_req     in  1       1-cycle pulse: start full-screen clear
//  busy          out 1       clear in progress
//  display_hold  out 1       to vga_display reset; high while busy
//  cpu_req       in  1       CPU write request; held until cpu_ack
//  cpu_addr      in  ADDR_W  CPU cell address
//  cpu_data      in  DATA_W  CPU cell value
//  cpu_ack       out 1       1-cycle pulse: CPU request consumed
//  kbd_req       in  1       console write request; held until kbd_ack
//  kbd_addr      in  ADDR_W  console cell address
//  kbd_data      in  DATA_W  console cell value
//  kbd_ack       out 1       1-cycle pulse: console request consumed
//  vram_addr     out ADDR_W  VRAM write address
//  vram_data     out DATA_W  VRAM write data
//  vram_we       out 1       VRAM write enable, one cycle per write
//  oob_err       out 1       sticky: an out-of-range request was dropped
// BEHAVIOUR
//  - All outputs registered. Reset: vram_addr=0, vram_data=0, vram_we=0, acks=0, oob_err=0,
//    busy=1, display_hold=1, state=CLEAR, clear counter=0, last_grant=KBD.
//  - States: CLEAR, SERVE.
//  - CLEAR: each cycle vram_we=1, vram_addr=cnt, vram_data=CLEAR_CELL, cnt++.
//    At cnt==SCREEN_CELLS-1: write that cell, next cycle -> SERVE with busy=0, display_hold=0.
//    Exactly 2000 writes, addresses 0..1999 in order, no gaps.
//  - CLEAR ignores clear_req (no restart) and gives no acks; requesters stall.
//  - SERVE with clear_req=1: -> CLEAR, cnt=0, busy=1 next cycle. Clear wins over a same-cycle request.
//  - SERVE arbitration on sampled req:
//    - Eligible: req=1 and own ack not high this cycle; prevents a double grant while the requester drops req.
//    - One eligible: grant it. Both eligible: grant the one != last_grant.
//    - last_grant updates on every grant.
//  - Grant latency: req sampled in cycle N -> vram_we/addr/data and xxx_ack valid in cycle N+1.
//    The ack coincides with the write.
//  - Out of range (addr >= SCREEN_CELLS): still acked, vram_we stays 0, oob_err set.
//    oob_err is cleared only by rst_n.
//  - Throughput: 1 write/cycle with both requesters active; one requester alone gets 1 write per 2 cycles.
//  - vram_we=0 in any cycle without a write; addr/data then hold their last value.
//  - rst_n asserted mid-clear or mid-grant: immediate return to reset values. Any pending ack is lost;
//    requesters re-present after reset.
// STRUCTURE
//  - Shared package vram_pkg: COLS, ROWS, SCREEN_CELLS, vram_addr_t, vram_cell_t, CLEAR_CELL;
//    state encoding localparams.
//  - One sub-module rr_arbiter2: 2-way round-robin. Inputs: clk, rst_n, req[1:0], en.
//    Outputs: one-hot grant[1:0]; holds last_grant internally.
//  - Clear counter and output registers stay in the top module.
// TESTING
//  - Reset release -> busy=1 for 2000 cycles.
//    vram_we=1 each cycle with addr 0..1999 and data 16'h0700; then busy=0 and display_hold=0.
//  - After clear, cpu_req with addr=5, data=16'h0748 -> next cycle vram_we=1, addr=5, data=16'h0748, cpu_ack=1.
//    No second write while req falls.
//  - cpu_req and kbd_req held continuously -> grants alternate CPU,KBD,CPU,...; one write per cycle; CPU first after reset.
//  - clear_req pulse in the same cycle as kbd_req -> clear runs, kbd_ack stays 0 for 2000 cycles.
//    The kbd write then occurs after the clear.
//  - kbd_req with addr=2000 -> kbd_ack=1, vram_we=0, oob_err=1 and stays 1.
//  - rst_n pulsed low at clear cnt=1000 -> outputs reset asynchronously; the clear restarts from addr 0.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared types and constants for the text-mode VRAM write path.
package vram_pkg;
  localparam int COLS         = 80;
  localparam int ROWS         = 25;
  localparam int SCREEN_CELLS = COLS * ROWS;
  localparam int ADDR_W       = 12;
  localparam int DATA_W       = 16;

  typedef logic [ADDR_W-1:0] vram_addr_t;
  typedef logic [DATA_W-1:0] vram_cell_t;

  // grey-on-black NUL
  localparam vram_cell_t CLEAR_CELL = 16'h0700;
  localparam vram_addr_t LAST_CELL  = vram_addr_t'(SCREEN_CELLS - 1);
  localparam vram_addr_t CELL_LIMIT = vram_addr_t'(SCREEN_CELLS);

  // scheduler state encoding
  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_SERVE = 1'b1;

  function automatic logic cell_in_range(input vram_addr_t addr);
    return addr < CELL_LIMIT;
  endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Bit 0 = CPU, bit 1 = console.
// After reset the console counts as last served, so the CPU wins the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);
  logic last_grant;

  // one-hot grant; a tie goes to whoever was not served last
  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // remember the winner of every grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= 1'b1;
    else if (|grant) last_grant <= grant[1];
  end
endmodule

// File: rtl/vram_write_scheduler.sv
// Owner of the VRAM write port: clears the screen after reset or on request,
// otherwise shares the port round-robin between CPU and console writer.
//
// state | meaning
// CLEAR | writing CLEAR_CELL to cells 0..SCREEN_CELLS-1, display held in reset
// SERVE | arbitrating CPU / console write requests
module vram_write_scheduler
  import vram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_req,
  output logic       busy,
  output logic       display_hold,
  input  logic       cpu_req,
  input  vram_addr_t cpu_addr,
  input  vram_cell_t cpu_data,
  output logic       cpu_ack,
  input  logic       kbd_req,
  input  vram_addr_t kbd_addr,
  input  vram_cell_t kbd_data,
  output logic       kbd_ack,
  output vram_addr_t vram_addr,
  output vram_cell_t vram_data,
  output logic       vram_we,
  output logic       oob_err
);
  logic       state_q, state_d;
  vram_addr_t cnt_q, cnt_d;
  logic [1:0] eligible, grant;
  logic       arb_en;
  vram_addr_t sel_addr;
  vram_cell_t sel_data;

  logic       we_d, cpu_ack_d, kbd_ack_d, oob_d, busy_d;
  vram_addr_t addr_d;
  vram_cell_t data_d;

  // a requester whose ack is showing is still dropping req, so skip it this cycle
  assign eligible = {kbd_req & ~kbd_ack, cpu_req & ~cpu_ack};
  assign arb_en   = (state_q == ST_SERVE) && !clear_req;
  assign sel_addr = grant[1] ? kbd_addr : cpu_addr;
  assign sel_data = grant[1] ? kbd_data : cpu_data;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (eligible),
    .en    (arb_en),
    .grant (grant)
  );

  // state and clear counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: sweep the screen once, then serve until a clear is requested
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (cnt_q == LAST_CELL) begin
          state_d = ST_SERVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    we_d      = 1'b0;
    addr_d    = vram_addr;
    data_d    = vram_data;
    cpu_ack_d = 1'b0;
    kbd_ack_d = 1'b0;
    oob_d     = oob_err;
    busy_d    = (state_d == ST_CLEAR);
    if (state_q == ST_CLEAR) begin
      we_d   = 1'b1;
      addr_d = cnt_q;
      data_d = CLEAR_CELL;
    end else if (|grant) begin
      cpu_ack_d = grant[0];
      kbd_ack_d = grant[1];
      if (cell_in_range(sel_addr)) begin
        we_d   = 1'b1;
        addr_d = sel_addr;
        data_d = sel_data;
      end else begin
        oob_d = 1'b1;
      end
    end
  end

  // output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vram_we      <= 1'b0;
      vram_addr    <= '0;
      vram_data    <= '0;
      cpu_ack      <= 1'b0;
      kbd_ack      <= 1'b0;
      oob_err      <= 1'b0;
      busy         <= 1'b1;
      display_hold <= 1'b1;
    end else begin
      vram_we      <= we_d;
      vram_addr    <= addr_d;
      vram_data    <= data_d;
      cpu_ack      <= cpu_ack_d;
      kbd_ack      <= kbd_ack_d;
      oob_err      <= oob_d;
      busy         <= busy_d;
      display_hold <= busy_d;
    end
  end
endmodule
